// File: rtl/aes_mmio_pkg.sv
// aes_mmio_pkg: shared state type, register-map index helpers and bit positions
package aes_mmio_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  localparam int ST_DONE = 0;
  localparam int ST_BUSY = 1;
  localparam int ST_TMO = 2;
  localparam int CT_START = 0;
  localparam int CT_IRQEN = 1;
  function automatic int ctrl_idx(input int k, input int m);
    return k + 2 * m;
  endfunction
  function automatic int status_idx(input int k, input int m);
    return k + 2 * m + 1;
  endfunction
  function automatic int expsel_idx(input int k, input int m);
    return k + 2 * m + 2;
  endfunction
  function automatic int num_regs(input int k, input int m);
    return k + 2 * m + 3;
  endfunction
endpackage

// File: rtl/avalon_aes_mmio_if.sv
// avalon_aes_mmio_if: Avalon-MM slave bus bundle with master/slave views
interface avalon_aes_mmio_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                  avs_chipselect;
  logic                  avs_read;
  logic                  avs_write;
  logic [ADDR_W-1:0]     avs_address;
  logic [DATA_W/8-1:0]   avs_byteenable;
  logic [DATA_W-1:0]     avs_writedata;
  logic [DATA_W-1:0]     avs_readdata;
  logic                  avs_readdatavalid;
  modport slave (
    input  avs_chipselect, avs_read, avs_write, avs_address, avs_byteenable, avs_writedata,
    output avs_readdata, avs_readdatavalid
  );
  modport master (
    output avs_chipselect, avs_read, avs_write, avs_address, avs_byteenable, avs_writedata,
    input  avs_readdata, avs_readdatavalid
  );
endinterface

// File: rtl/aes_mmio_fsm.sv
// aes_mmio_fsm: start/done control with timeout counter and sticky done/timeout flags
module aes_mmio_fsm
  import aes_mmio_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   start_req,
  input  logic   stop_req,
  input  logic   aes_done,
  input  logic   done_clr,
  input  logic   tmo_clr,
  output state_e state,
  output logic   aes_start,
  output logic   done,
  output logic   timeout,
  output logic   capture,
  output logic   tmo_evt
);
  localparam int CNT_W = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_d, done_q, done_d, tmo_q, tmo_d;
  assign capture = state_q == BUSY && aes_done;
  // done in the same cycle as expiry suppresses the timeout
  assign tmo_evt = TIMEOUT_CYC != 0 && state_q == BUSY && !aes_done && cnt_q == CNT_W'(TIMEOUT_CYC - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + CNT_W'(1);
    start_d = 1'b0;
    done_d = capture | (done_q & ~done_clr);
    tmo_d = tmo_evt | (tmo_q & ~tmo_clr);
    if (state_q == IDLE && start_req) begin
      state_d = BUSY;
      start_d = 1'b1;
      cnt_d = '0;
    end else if (capture) state_d = DONE;
    else if (tmo_evt) state_d = IDLE;
    else if (state_q == DONE && stop_req) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      start_q <= 1'b0;
      done_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      start_q <= start_d;
      done_q <= done_d;
      tmo_q <= tmo_d;
    end
  end
  assign state = state_q;
  assign aes_start = start_q;
  assign done = done_q;
  assign timeout = tmo_q;
endmodule

// File: rtl/avalon_aes_mmio.sv
// avalon_aes_mmio: Avalon-MM register file, read mux and export select around an AES core
module avalon_aes_mmio
  import aes_mmio_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int KEY_WORDS   = 4,
  parameter int MSG_WORDS   = 4,
  parameter int ADDR_W      = 5,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  avalon_aes_mmio_if.slave              avs,
  output logic                          irq,
  output logic                          aes_start,
  output logic [DATA_W*KEY_WORDS-1:0]   aes_key,
  output logic [DATA_W*MSG_WORDS-1:0]   aes_msg_in,
  input  logic                          aes_done,
  input  logic [DATA_W*MSG_WORDS-1:0]   aes_msg_out,
  output logic [DATA_W-1:0]             aes_export_data
);
  localparam int CTRL = ctrl_idx(KEY_WORDS, MSG_WORDS);
  localparam int STATUS = status_idx(KEY_WORDS, MSG_WORDS);
  localparam int EXPSEL = expsel_idx(KEY_WORDS, MSG_WORDS);
  localparam int NREG = num_regs(KEY_WORDS, MSG_WORDS);
  logic [KEY_WORDS-1:0][DATA_W-1:0] key_q, key_d;
  logic [MSG_WORDS-1:0][DATA_W-1:0] msg_en_q, msg_en_d, msg_de_q, msg_de_d;
  logic [1:0]                       ctrl_q, ctrl_d, ctrl_w;
  logic [DATA_W-1:0]                expsel_q, expsel_d, readdata_q, readdata_d, be_mask;
  logic                             readdatavalid_q, readdatavalid_d, irq_q, irq_d;
  logic [NREG-1:0]                  wr_hit, rd_hit, ex_hit;
  logic [NREG-1:0][DATA_W-1:0]      rf;
  logic [NREG:0][DATA_W-1:0]        rd_acc, ex_acc;
  state_e                           state;
  logic                             busy, done, timeout, capture, tmo_evt, wr_en, rd_en;
  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] o, w, m);
    return (o & ~m) | (w & m);
  endfunction
  assign wr_en = avs.avs_chipselect & avs.avs_write;
  assign rd_en = avs.avs_chipselect & avs.avs_read;
  assign busy = state == BUSY;
  assign rf = {expsel_q, DATA_W'({timeout, busy, done}), DATA_W'(ctrl_q), msg_de_q, msg_en_q, key_q};
  assign rd_acc[0] = '0;
  assign ex_acc[0] = '0;
  for (genvar b = 0; b < DATA_W / 8; b++) begin : g_lane
    assign be_mask[8*b +: 8] = {8{avs.avs_byteenable[b]}};
  end
  // one-hot address decode folded into OR chains; unmapped indices fall through as 0
  for (genvar g = 0; g < NREG; g++) begin : g_sel
    assign rd_hit[g] = avs.avs_address == ADDR_W'(g);
    assign wr_hit[g] = wr_en & rd_hit[g];
    assign ex_hit[g] = expsel_q == DATA_W'(g);
    assign rd_acc[g+1] = rd_acc[g] | (rd_hit[g] ? rf[g] : '0);
    assign ex_acc[g+1] = ex_acc[g] | (ex_hit[g] ? rf[g] : '0);
  end
  for (genvar g = 0; g < KEY_WORDS; g++) begin : g_key
    assign key_d[g] = wr_hit[g] && !busy ? merge(key_q[g], avs.avs_writedata, be_mask) : key_q[g];
  end
  for (genvar g = 0; g < MSG_WORDS; g++) begin : g_msg
    assign msg_en_d[g] = wr_hit[KEY_WORDS+g] && !busy ? merge(msg_en_q[g], avs.avs_writedata, be_mask) : msg_en_q[g];
  end
  always_comb begin
    ctrl_w = avs.avs_byteenable[0] ? avs.avs_writedata[1:0] : ctrl_q;
    ctrl_d[CT_IRQEN] = wr_hit[CTRL] ? ctrl_w[CT_IRQEN] : ctrl_q[CT_IRQEN];
    ctrl_d[CT_START] = tmo_evt ? 1'b0 : wr_hit[CTRL] && !busy ? ctrl_w[CT_START] : ctrl_q[CT_START];
    msg_de_d = capture ? aes_msg_out : msg_de_q;
    expsel_d = wr_hit[EXPSEL] ? merge(expsel_q, avs.avs_writedata, be_mask) : expsel_q;
    readdata_d = rd_en ? rd_acc[NREG] : readdata_q;
    readdatavalid_d = rd_en;
    irq_d = ctrl_q[CT_IRQEN] & (done | timeout);
  end
  aes_mmio_fsm #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_fsm (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .start_req (ctrl_d[CT_START] & ~ctrl_q[CT_START]),
    .stop_req  (~ctrl_d[CT_START]),
    .aes_done  (aes_done),
    .done_clr  (wr_hit[STATUS] & avs.avs_byteenable[0] & avs.avs_writedata[ST_DONE]),
    .tmo_clr   (wr_hit[STATUS] & avs.avs_byteenable[0] & avs.avs_writedata[ST_TMO]),
    .state     (state),
    .aes_start (aes_start),
    .done      (done),
    .timeout   (timeout),
    .capture   (capture),
    .tmo_evt   (tmo_evt)
  );
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      key_q <= '0;
      msg_en_q <= '0;
      msg_de_q <= '0;
      ctrl_q <= '0;
      expsel_q <= '0;
      readdata_q <= '0;
      readdatavalid_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      key_q <= key_d;
      msg_en_q <= msg_en_d;
      msg_de_q <= msg_de_d;
      ctrl_q <= ctrl_d;
      expsel_q <= expsel_d;
      readdata_q <= readdata_d;
      readdatavalid_q <= readdatavalid_d;
      irq_q <= irq_d;
    end
  end
  assign aes_key = key_q;
  assign aes_msg_in = msg_en_q;
  assign aes_export_data = ex_acc[NREG];
  assign avs.avs_readdata = readdata_q;
  assign avs.avs_readdatavalid = readdatavalid_q;
  assign irq = irq_q;
endmodule

// File: tb/tb_avalon_aes_mmio.sv
// tb_avalon_aes_mmio: randomized register traffic plus directed start/done/timeout/reset scenarios
module tb_avalon_aes_mmio;
  localparam int K = 4, M = 4, AW = 5;
  localparam int CTRL = K + 2 * M, STAT = CTRL + 1, EXPS = CTRL + 2, NREG = CTRL + 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  avalon_aes_mmio_if #(.DATA_W(32), .ADDR_W(AW)) bus ();
  logic         irq, aes_start, aes_done;
  logic [127:0] aes_key, aes_msg_in, aes_msg_out;
  logic [31:0]  aes_export_data;
  avalon_aes_mmio #(.DATA_W(32), .KEY_WORDS(K), .MSG_WORDS(M), .ADDR_W(AW), .TIMEOUT_CYC(8)) dut (
    .clk_clk         (clk),
    .reset_reset_n   (rst_n),
    .avs             (bus),
    .irq             (irq),
    .aes_start       (aes_start),
    .aes_key         (aes_key),
    .aes_msg_in      (aes_msg_in),
    .aes_done        (aes_done),
    .aes_msg_out     (aes_msg_out),
    .aes_export_data (aes_export_data)
  );
  int checks = 0, errors = 0;
  logic [31:0] m_key [K];
  logic [31:0] m_msg [M];
  logic [31:0] m_de [M];
  logic [31:0] m_expsel;
  logic [1:0]  m_ctrl;
  logic [2:0]  m_stat;
  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] w, input logic [3:0] be);
    logic [31:0] r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r = (r & ~(32'hFF << (8 * i))) | (w & (32'hFF << (8 * i)));
    return r;
  endfunction
  function automatic logic [31:0] model_reg(input int a);
    if (a < K) return m_key[a];
    if (a < K + M) return m_msg[a-K];
    if (a < K + 2 * M) return m_de[a-K-M];
    if (a == CTRL) return {30'd0, m_ctrl};
    if (a == STAT) return {29'd0, m_stat};
    if (a == EXPS) return m_expsel;
    return 32'd0;
  endfunction
  function automatic logic [31:0] model_export();
    return m_expsel < NREG ? model_reg(int'(m_expsel)) : 32'd0;
  endfunction
  function automatic logic [127:0] pack4(input logic [31:0] w [4]);
    logic [127:0] r = '0;
    for (int i = 0; i < 4; i++) r |= 128'(w[i]) << (32 * i);
    return r;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_key[i] = '0;
      m_msg[i] = '0;
      m_de[i] = '0;
    end
    m_expsel = '0;
    m_ctrl = '0;
    m_stat = '0;
  endtask
  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be = 4'hF);
    bus.avs_chipselect = 1'b1;
    bus.avs_write = 1'b1;
    bus.avs_address = AW'(a);
    bus.avs_byteenable = be;
    bus.avs_writedata = d;
    @(negedge clk);
    bus.avs_chipselect = 1'b0;
    bus.avs_write = 1'b0;
  endtask
  task automatic rd_chk(input string tag, input int a, input logic [31:0] exp);
    bus.avs_chipselect = 1'b1;
    bus.avs_read = 1'b1;
    bus.avs_address = AW'(a);
    @(negedge clk);
    bus.avs_chipselect = 1'b0;
    bus.avs_read = 1'b0;
    check({tag, "_valid"}, bus.avs_readdatavalid, 1);
    check(tag, bus.avs_readdata, exp);
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic capture_model();
    for (int i = 0; i < M; i++) m_de[i] = 32'(aes_msg_out >> (32 * i));
  endtask
  initial begin
    bus.avs_chipselect = 1'b0;
    bus.avs_read = 1'b0;
    bus.avs_write = 1'b0;
    bus.avs_address = '0;
    bus.avs_byteenable = '0;
    bus.avs_writedata = '0;
    aes_done = 1'b0;
    aes_msg_out = '0;
    model_reset();
    idle(3);
    check("rst_readdata", bus.avs_readdata, 0);
    check("rst_valid", bus.avs_readdatavalid, 0);
    check("rst_irq", irq, 0);
    check("rst_start", aes_start, 0);
    check("rst_key", aes_key, 0);
    rst_n = 1'b1;
    idle(1);
    wr(0, 32'hDEADBEEF);
    wr(0, 32'h00000011, 4'b0001);
    m_key[0] = lanes(lanes(32'h0, 32'hDEADBEEF, 4'hF), 32'h11, 4'b0001);
    rd_chk("key0_lanes", 0, 32'hDEADBE11);
    idle(1);
    check("valid_one_cycle", bus.avs_readdatavalid, 0);
    for (int it = 0; it < 60; it++) begin
      int a;
      logic [31:0] d;
      logic [3:0] be;
      a = $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) begin
        if (a == CTRL || a == STAT) a = 0;
        d = (a == EXPS) ? 32'($urandom_range(0, 20)) : 32'($urandom);
        be = 4'($urandom_range(0, 15));
        wr(a, d, be);
        if (a < K) m_key[a] = lanes(m_key[a], d, be);
        else if (a < K + M) m_msg[a-K] = lanes(m_msg[a-K], d, be);
        else if (a == EXPS) m_expsel = lanes(m_expsel, d, be);
      end else rd_chk("rand_rd", a, model_reg(a));
      check("rand_export", aes_export_data, model_export());
    end
    check("rand_key_bus", aes_key, pack4(m_key));
    check("rand_msg_bus", aes_msg_in, pack4(m_msg));
    m_msg[0] = 32'hA5A5A5A5;
    wr(K, m_msg[0]);
    wr(EXPS, K);
    m_expsel = K;
    check("export_msg_en0", aes_export_data, 32'hA5A5A5A5);
    wr(EXPS, 31);
    m_expsel = 31;
    check("export_unmapped", aes_export_data, 0);
    for (int i = 0; i < K; i++) begin
      m_key[i] = $urandom;
      wr(i, m_key[i]);
    end
    for (int i = 0; i < M; i++) begin
      m_msg[i] = $urandom;
      wr(K + i, m_msg[i]);
    end
    check("enc_key_bus", aes_key, pack4(m_key));
    check("enc_msg_bus", aes_msg_in, pack4(m_msg));
    wr(CTRL, 3);
    m_ctrl = 3;
    check("start_pulse", aes_start, 1);
    wr(1, 32'h55);
    check("start_one_cycle", aes_start, 0);
    aes_msg_out = 128'h0123456789ABCDEF0123456789ABCDEF;
    aes_done = 1'b1;
    rd_chk("status_preset", STAT, 32'h2);
    aes_done = 1'b0;
    capture_model();
    m_stat = 3'b001;
    rd_chk("status_done", STAT, model_reg(STAT));
    check("irq_done", irq, 1);
    for (int i = 0; i < M; i++) rd_chk("msg_de", K + M + i, m_de[i]);
    rd_chk("key1_busy_write", 1, m_key[1]);
    rd_chk("ctrl_in_done", CTRL, 3);
    wr(CTRL, 2);
    m_ctrl = 2;
    rd_chk("status_after_stop", STAT, 32'h1);
    wr(STAT, 1);
    m_stat = 0;
    rd_chk("status_w1c_done", STAT, 0);
    check("irq_done_clear", irq, 0);
    wr(CTRL, 3);
    m_ctrl = 3;
    idle(6);
    rd_chk("tmo_cycle7", STAT, 32'h2);
    rd_chk("tmo_cycle8_preset", STAT, 32'h2);
    m_stat = 3'b100;
    m_ctrl = 2;
    rd_chk("tmo_set", STAT, model_reg(STAT));
    rd_chk("tmo_ctrl_cleared", CTRL, model_reg(CTRL));
    check("irq_tmo", irq, 1);
    rd_chk("tmo_msg_de_kept", K + M, m_de[0]);
    wr(STAT, 4);
    m_stat = 0;
    rd_chk("tmo_w1c", STAT, 0);
    check("irq_tmo_clear", irq, 0);
    wr(CTRL, 3);
    m_ctrl = 3;
    idle(7);
    aes_msg_out = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
    aes_done = 1'b1;
    idle(1);
    aes_done = 1'b0;
    capture_model();
    m_stat = 3'b001;
    rd_chk("done_beats_tmo", STAT, model_reg(STAT));
    rd_chk("done_beats_tmo_ctrl", CTRL, 3);
    for (int i = 0; i < M; i++) rd_chk("msg_de_tie", K + M + i, m_de[i]);
    wr(CTRL, 2);
    wr(STAT, 1);
    wr(EXPS, K);
    m_expsel = K;
    check("export_pre_reset", aes_export_data, m_msg[0]);
    wr(CTRL, 3);
    idle(2);
    rst_n = 1'b0;
    #1;
    check("arst_readdata", bus.avs_readdata, 0);
    check("arst_valid", bus.avs_readdatavalid, 0);
    check("arst_irq", irq, 0);
    check("arst_start", aes_start, 0);
    check("arst_key", aes_key, 0);
    check("arst_msg_in", aes_msg_in, 0);
    check("arst_export", aes_export_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    aes_msg_out = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
    aes_done = 1'b1;
    idle(1);
    aes_done = 1'b0;
    for (int i = 0; i < M; i++) rd_chk("late_done_ignored", K + M + i, m_de[i]);
    rd_chk("post_rst_status", STAT, 0);
    rd_chk("post_rst_ctrl", CTRL, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
